seg_scan_ctrl_io: RTL and testbench
===================================

SEG_SCAN_CTRL_IO -- requirements
Module: seg_scan_ctrl_io

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hD0, first byte of the register window.
REQ-002 SHALL have parameter NUM_DIGITS, default 4, legal 1..8, number of multiplexed digits.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot (>=2).
REQ-004 SHALL have parameter BLINK_FRAMES, default 32, frames per blink half-period (>=1).
REQ-005 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port BUS_DATA  inout  8  shared data bus, tristated when not reading.
REQ-008 SHALL have port BUS_ADDR  input  8  bus address.
REQ-009 SHALL have port BUS_WE  input  1  1 = write, 0 = read.
REQ-010 SHALL have port SEG_SELECT  output  NUM_DIGITS  digit enables, active-low, one-hot-low or all high.
REQ-011 SHALL have port DEC_OUT  output  8  segments, active-low, bit7 = decimal point, bits6:0 = g..a.
REQ-012 SHALL have port FRAME_TICK  output  1  one-cycle pulse at end of each full scan.

Function
REQ-013 SHALL map digit registers DIG[k] at BASE_ADDR+k (k<NUM_DIGITS): bit7 DP, bits4:0 value; value 0x00-0x0F hex glyph, any other value blank; bits6:5 stored, read back.
REQ-014 SHALL map CTRL at BASE_ADDR+NUM_DIGITS: bit0 EN, bit1 RAW (DIG bits6:0 drive segments directly, active-high in register), bits7:4 BRIGHT; bits3:2 read 0.
REQ-015 SHALL map BLINK mask at BASE_ADDR+NUM_DIGITS+1: bit k set = digit k blinks; bits >= NUM_DIGITS read 0.
REQ-016 SHALL map read-only STATUS at BASE_ADDR+NUM_DIGITS+2: bits2:0 current digit index, bit3 blink phase, bits7:4 0; writes ignored.
REQ-017 SHALL ignore bus cycles outside BASE_ADDR..BASE_ADDR+NUM_DIGITS+2 and release BUS_DATA the next cycle.
REQ-018 SHALL perform writes in the cycle BUS_WE=1 with address in window; DIG/CTRL/BLINK writes land in staging registers.
REQ-019 SHALL answer reads with 1-cycle latency: in-window address with BUS_WE=0 at edge N -> BUS_DATA driven with staging/STATUS value from edge N+1 until the edge after the read condition ends.
REQ-020 SHALL scan with prescaler 0..SCAN_DIV-1; at terminal count digit index advances, wrapping NUM_DIGITS-1 -> 0.
REQ-021 SHALL pulse FRAME_TICK for exactly one cycle on the wrap NUM_DIGITS-1 -> 0.
REQ-022 SHALL copy staging DIG/BLINK to active shadow on the FRAME_TICK cycle; a write in that same cycle commits at the next frame (tear-free display).
REQ-023 SHALL drive only active shadow to outputs; CTRL takes effect immediately, not shadowed.
REQ-024 SHALL apply PWM: free-running 4-bit counter p increments every clock; segments and SEG_SELECT active only while p <= BRIGHT (duty (BRIGHT+1)/16; 0xF = always on).
REQ-025 SHALL toggle blink phase every BLINK_FRAMES frames; phase 1 blanks digits whose active BLINK bit is set (SEG_SELECT bit stays high).
REQ-026 SHALL, when EN=0, hold SEG_SELECT and DEC_OUT all high, hold prescaler, digit index, blink count and phase at 0, FRAME_TICK 0, and copy staging to shadow every cycle.
REQ-027 SHALL register SEG_SELECT and DEC_OUT (one-cycle pipeline after index/PWM state), glitch-free.

Reset
REQ-028 SHALL on RESET low asynchronously set: DIG staging/shadow 8'h10 (blank), CTRL 8'hF1 (EN=1, BRIGHT=F, RAW=0), BLINK 0, prescaler/index/p/blink state 0, bus driver off.
REQ-029 SHALL hold SEG_SELECT and DEC_OUT all high and FRAME_TICK 0 during reset; scan restarts from digit 0 on release, mid-frame state discarded.

Structure
REQ-030 SHALL place register offsets, blank code 5'h10, CTRL bit positions and the 16-entry hex segment table in shared package seg_scan_pkg.
REQ-031 SHALL instantiate one sub-module seg_hex_decode (combinational 5-bit value -> 7 active-low segments, blank for >0x0F).

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-032 SHALL test reset: RESET low mid-scan -> SEG_SELECT=4'hF, DEC_OUT=8'hFF immediately; read CTRL (0xD4) -> 8'hF1 one cycle later.
REQ-033 SHALL test write/commit: write 0xD0=0x83 mid-frame -> digit 0 still blank this frame; after FRAME_TICK, slot 0 shows DEC_OUT=8'h30 ('3', DP on), SEG_SELECT=4'hE.
REQ-034 SHALL test scan: EN=1 -> SEG_SELECT sequence E,D,B,7 every 4 clocks, FRAME_TICK one cycle every 16 clocks.
REQ-035 SHALL test PWM: BRIGHT=3 -> outputs active 4 of every 16 clocks; BRIGHT=0 -> 1 of 16.
REQ-036 SHALL test blink/disable: BLINK (0xD5)=0x02 -> digit 1 blanked on alternating 2-frame periods, STATUS bit3 toggles; CTRL=0x00 -> outputs all high, STATUS=0x00.
REQ-037 SHALL test bus edges: read 0xD7 or write 0xD6 -> bus stays Z, no state change; read 0xD6 -> current index in bits2:0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// register map offsets, CTRL field positions, reset codes and the hex glyph table.
package seg_scan_pkg;

    typedef enum logic [1:0] {RegDig, RegCtrl, RegBlink, RegStatus} reg_sel_e;

    // Offsets of the control registers relative to the end of the digit block
    localparam logic [7:0] OFS_CTRL   = 8'd0;
    localparam logic [7:0] OFS_BLINK  = 8'd1;
    localparam logic [7:0] OFS_STATUS = 8'd2;

    localparam logic [4:0] BLANK_CODE = 5'h10;
    localparam logic [7:0] DIG_RESET  = 8'h10;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_RAW_BIT    = 1;
    localparam int unsigned CTRL_BRIGHT_LSB = 4;
    localparam logic [7:0]  CTRL_RESET      = 8'hF1;
    localparam logic [7:0]  CTRL_WR_MASK    = 8'hF3;

    // Active-low g..a patterns, entry 0 at the least significant end
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 5-bit digit code to active-low g..a segments; codes above 0x0F are blank.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [4:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        if (value < BLANK_CODE) begin
            seg = HEX_SEG[value[3:0]];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl_io.sv
// Bus-mapped seven-segment scan controller: staged/shadowed digit registers,
// digit multiplexing, PWM brightness and per-digit blink, registered outputs.
module seg_scan_ctrl_io
    import seg_scan_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'hD0,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    inout  wire  [7:0]            BUS_DATA,
    input  logic [7:0]            BUS_ADDR,
    input  logic                  BUS_WE,
    output logic [NUM_DIGITS-1:0] SEG_SELECT,
    output logic [7:0]            DEC_OUT,
    output logic                  FRAME_TICK
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    IDX_MAX   = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]    NUM_D8    = 8'(NUM_DIGITS);

    logic [7:0]            dig_stage_q [NUM_DIGITS];
    logic [7:0]            dig_stage_d [NUM_DIGITS];
    logic [7:0]            dig_shadow_q [NUM_DIGITS];
    logic [7:0]            dig_shadow_d [NUM_DIGITS];
    logic [7:0]            ctrl_q, ctrl_d;
    logic [NUM_DIGITS-1:0] blink_stage_q, blink_stage_d;
    logic [NUM_DIGITS-1:0] blink_shadow_q, blink_shadow_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [2:0]            idx_q, idx_d;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [3:0]            pwm_q;
    logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
    logic [7:0]            dec_q, dec_d;
    logic                  rd_en_q;
    logic [7:0]            rd_data_q, rd_data_d;

    logic [7:0] ofs;
    reg_sel_e   reg_sel;
    logic       in_win, wr_en, rd_req;
    logic       en, presc_tc, frame_tick;
    logic [7:0] cur_dig;
    logic       cur_blink, show;
    logic [6:0] hex_seg;

    assign ofs = BUS_ADDR - BASE_ADDR;

    always_comb begin
        reg_sel = RegDig;
        in_win  = 1'b1;
        if (ofs < NUM_D8) begin
            reg_sel = RegDig;
        end else if (ofs == NUM_D8 + OFS_CTRL) begin
            reg_sel = RegCtrl;
        end else if (ofs == NUM_D8 + OFS_BLINK) begin
            reg_sel = RegBlink;
        end else if (ofs == NUM_D8 + OFS_STATUS) begin
            reg_sel = RegStatus;
        end else begin
            in_win = 1'b0;
        end
    end

    assign wr_en  = BUS_WE && in_win;
    assign rd_req = !BUS_WE && in_win;

    assign en         = ctrl_q[CTRL_EN_BIT];
    assign presc_tc   = (presc_q == PRESC_MAX);
    assign frame_tick = en && presc_tc && (idx_q == IDX_MAX);

    // Disabled scan collapses to a fresh frame start so re-enable begins at digit 0
    always_comb begin
        presc_d     = '0;
        idx_d       = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (en) begin
            presc_d     = presc_tc ? '0 : presc_q + 1'b1;
            idx_d       = idx_q;
            blink_cnt_d = blink_cnt_q;
            phase_d     = phase_q;
            if (presc_tc) begin
                idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
            end
            if (frame_tick) begin
                if (blink_cnt_q == BLINK_MAX) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end
    end

    // Shadow copies the pre-edge staging value, so a write on the tick cycle waits a frame
    always_comb begin
        dig_stage_d    = dig_stage_q;
        dig_shadow_d   = dig_shadow_q;
        ctrl_d         = ctrl_q;
        blink_stage_d  = blink_stage_q;
        blink_shadow_d = blink_shadow_q;
        if (!en || frame_tick) begin
            dig_shadow_d   = dig_stage_q;
            blink_shadow_d = blink_stage_q;
        end
        if (wr_en) begin
            case (reg_sel)
                RegDig: begin
                    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                        if (ofs[2:0] == 3'(k)) dig_stage_d[k] = BUS_DATA;
                    end
                end
                RegCtrl:   ctrl_d = BUS_DATA & CTRL_WR_MASK;
                RegBlink:  blink_stage_d = BUS_DATA[NUM_DIGITS-1:0];
                RegStatus: ;
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        case (reg_sel)
            RegDig: begin
                for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                    if (ofs[2:0] == 3'(k)) rd_data_d = dig_stage_q[k];
                end
            end
            RegCtrl:   rd_data_d = ctrl_q;
            RegBlink:  rd_data_d = 8'(blink_stage_q);
            RegStatus: rd_data_d = {4'h0, phase_q, idx_q};
        endcase
    end

    always_comb begin
        cur_dig   = dig_shadow_q[0];
        cur_blink = blink_shadow_q[0];
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == 3'(k)) begin
                cur_dig   = dig_shadow_q[k];
                cur_blink = blink_shadow_q[k];
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .value (cur_dig[4:0]),
        .seg   (hex_seg)
    );

    assign show = en && (pwm_q <= ctrl_q[CTRL_BRIGHT_LSB +: 4]) && !(cur_blink && phase_q);

    always_comb begin
        seg_sel_d = '1;
        dec_d     = '1;
        if (show) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                seg_sel_d[k] = (idx_q != 3'(k));
            end
            dec_d = {~cur_dig[7], ctrl_q[CTRL_RAW_BIT] ? ~cur_dig[6:0] : hex_seg};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dig_stage_q    <= '{default: DIG_RESET};
            dig_shadow_q   <= '{default: DIG_RESET};
            ctrl_q         <= CTRL_RESET;
            blink_stage_q  <= '0;
            blink_shadow_q <= '0;
            presc_q        <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            phase_q        <= 1'b0;
            pwm_q          <= '0;
            seg_sel_q      <= '1;
            dec_q          <= '1;
            rd_en_q        <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            dig_stage_q    <= dig_stage_d;
            dig_shadow_q   <= dig_shadow_d;
            ctrl_q         <= ctrl_d;
            blink_stage_q  <= blink_stage_d;
            blink_shadow_q <= blink_shadow_d;
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
            pwm_q          <= pwm_q + 4'd1;
            seg_sel_q      <= seg_sel_d;
            dec_q          <= dec_d;
            rd_en_q        <= rd_req;
            rd_data_q      <= rd_data_d;
        end
    end

    assign BUS_DATA   = rd_en_q ? rd_data_q : 8'hzz;
    assign SEG_SELECT = seg_sel_q;
    assign DEC_OUT    = dec_q;
    assign FRAME_TICK = frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl_io.sv
// Bench for seg_scan_ctrl_io: directed steps plus random bus traffic, checked every
// cycle against a time-based behavioural model of scan, blink, PWM and the register map.
module tb_seg_scan_ctrl_io;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = ND * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr;
    logic       we;
    logic [7:0] tb_bus;
    logic       tb_drv;
    tri1  [7:0] bus_data;
    logic [3:0] seg_sel;
    logic [7:0] dec_out;
    logic       frame_tick;

    assign bus_data = tb_drv ? tb_bus : 8'hzz;

    always #5 clk = ~clk;

    seg_scan_ctrl_io #(
        .BASE_ADDR    (8'hD0),
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .BUS_DATA   (bus_data),
        .BUS_ADDR   (addr),
        .BUS_WE     (we),
        .SEG_SELECT (seg_sel),
        .DEC_OUT    (dec_out),
        .FRAME_TICK (frame_tick)
    );

    int checks = 0;
    int errors = 0;

    // Model: scan position derives from m_t (enabled clocks since frame restart),
    // PWM from m_p (clocks since reset).
    int         m_t, m_p;
    logic [7:0] m_stage [ND];
    logic [7:0] m_shadow [ND];
    logic [7:0] m_ctrl;
    logic [3:0] m_bstage, m_bshadow;
    logic [3:0] m_sel;
    logic [7:0] m_dec;
    logic       m_rd_en;
    logic [7:0] m_rd;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lit segments, bit0 = a .. bit6 = g
    function automatic logic [6:0] lit_segs(input logic [4:0] v);
        case (v)
            5'h00: return 7'h3F;  5'h01: return 7'h06;  5'h02: return 7'h5B;
            5'h03: return 7'h4F;  5'h04: return 7'h66;  5'h05: return 7'h6D;
            5'h06: return 7'h7D;  5'h07: return 7'h07;  5'h08: return 7'h7F;
            5'h09: return 7'h6F;  5'h0A: return 7'h77;  5'h0B: return 7'h7C;
            5'h0C: return 7'h39;  5'h0D: return 7'h5E;  5'h0E: return 7'h79;
            5'h0F: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_p = 0;
        for (int i = 0; i < ND; i++) begin
            m_stage[i]  = 8'h10;
            m_shadow[i] = 8'h10;
        end
        m_ctrl    = 8'hF1;
        m_bstage  = 4'h0;
        m_bshadow = 4'h0;
        m_sel     = 4'hF;
        m_dec     = 8'hFF;
        m_rd_en   = 1'b0;
        m_rd      = 8'h00;
    endtask

    task automatic model_edge();
        int         idx, p;
        logic       phase, en, on;
        logic [7:0] d, ofs;
        if (!rst_n) begin
            model_reset();
            return;
        end
        en    = m_ctrl[0];
        idx   = (m_t / SD) % ND;
        p     = m_p % 16;
        phase = (((m_t / FRAME) / BF) % 2) == 1;
        d     = m_shadow[idx];
        on    = en && (p <= int'(m_ctrl[7:4])) && !(m_bshadow[idx] && phase);
        m_sel = 4'hF;
        m_dec = 8'hFF;
        if (on) begin
            m_sel[idx] = 1'b0;
            m_dec = {~d[7], m_ctrl[1] ? ~d[6:0] : ~lit_segs(d[4:0])};
        end
        if (!en || (m_t % FRAME == FRAME - 1)) begin
            m_shadow  = m_stage;
            m_bshadow = m_bstage;
        end
        ofs     = addr - 8'hD0;
        m_rd_en = !we && (ofs <= 8'd6);
        if (ofs < 8'd4)       m_rd = m_stage[ofs[1:0]];
        else if (ofs == 8'd4) m_rd = m_ctrl;
        else if (ofs == 8'd5) m_rd = {4'h0, m_bstage};
        else if (ofs == 8'd6) m_rd = {4'h0, phase, 3'(idx)};
        if (we) begin
            if (ofs < 8'd4)       m_stage[ofs[1:0]] = bus_data;
            else if (ofs == 8'd4) m_ctrl = bus_data & 8'hF3;
            else if (ofs == 8'd5) m_bstage = bus_data[3:0];
        end
        m_t = en ? m_t + 1 : 0;
        m_p++;
    endtask

    task automatic tick();
        logic exp_ft, rel;
        @(posedge clk);
        model_edge();
        #1;
        chk("seg_select", {4'h0, seg_sel}, {4'h0, m_sel});
        chk("dec_out", dec_out, m_dec);
        exp_ft = rst_n && m_ctrl[0] && (m_t % FRAME == FRAME - 1);
        chk("frame_tick", {7'h0, frame_tick}, {7'h0, exp_ft});
        if (m_rd_en) begin
            chk("bus_read", bus_data, m_rd);
        end else if (!tb_drv) begin
            rel = (bus_data === 8'hzz) || (bus_data === 8'hFF);
            chk("bus_release", {7'h0, rel}, 8'h01);
        end
    endtask

    task automatic bus_idle();
        addr   = 8'h00;
        we     = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        we     = 1'b1;
        tb_bus = d;
        tb_drv = 1'b1;
        tick();
        bus_idle();
        tick();
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        addr   = a;
        we     = 1'b0;
        tb_drv = 1'b0;
        tick();
        d = bus_data;
        bus_idle();
        tick();
    endtask

    task automatic wait_ft();
        int n = 0;
        while (!frame_tick && n < 40) begin
            tick();
            n++;
        end
        chk("frame_tick_timeout", {7'h0, frame_tick}, 8'h01);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, s1, s2;
        logic [3:0] exp_sel;
        int         cnt, op;

        bus_idle();
        tb_bus = 8'h00;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();

        // Asynchronous reset mid-scan
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_seg_select", {4'h0, seg_sel}, 8'h0F);
        chk("rst_dec_out", dec_out, 8'hFF);
        chk("rst_frame_tick", {7'h0, frame_tick}, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        rd(8'hD4, d);
        chk("ctrl_reset_read", d, 8'hF1);

        // Scan order and frame tick rate
        wait_ft();
        tick();
        cnt = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            exp_sel = 4'hF ^ (4'b0001 << (j / 4));
            chk("scan_order", {4'h0, seg_sel}, {4'h0, exp_sel});
            if (frame_tick) cnt++;
        end
        chk("frame_tick_count", 8'(cnt), 8'd1);

        // Tear-free commit of a mid-frame write
        wait_ft();
        repeat (3) tick();
        wr(8'hD0, 8'h83);
        chk("commit_pending_sel", {4'h0, seg_sel}, 8'h0E);
        chk("commit_pending_dec", dec_out, 8'hFF);
        wait_ft();
        tick();
        tick();
        chk("commit_sel", {4'h0, seg_sel}, 8'h0E);
        chk("commit_dec", dec_out, 8'h30);

        // PWM duty
        wr(8'hD4, 8'h31);
        cnt = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (seg_sel != 4'hF) cnt++;
        end
        chk("pwm_bright3", 8'(cnt), 8'd4);
        wr(8'hD4, 8'h01);
        cnt = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (seg_sel != 4'hF) cnt++;
        end
        chk("pwm_bright0", 8'(cnt), 8'd1);

        // Blink on digit 1
        wr(8'hD4, 8'hF1);
        wr(8'hD1, 8'h05);
        wr(8'hD5, 8'h02);
        wait_ft();
        cnt = 0;
        for (int j = 0; j < 64; j++) begin
            tick();
            if (seg_sel == 4'hD) cnt++;
        end
        chk("blink_visible_slots", 8'(cnt), 8'd8);
        rd(8'hD6, s1);
        repeat (30) tick();
        rd(8'hD6, s2);
        chk("status_phase_toggle", s1 ^ s2, 8'h08);

        // Disable
        wr(8'hD4, 8'h00);
        tick();
        chk("disabled_sel", {4'h0, seg_sel}, 8'h0F);
        chk("disabled_dec", dec_out, 8'hFF);
        rd(8'hD6, d);
        chk("disabled_status", d, 8'h00);

        // Out-of-window and read-only accesses
        rd(8'hD7, d);
        chk("outside_read_release", {7'h0, (d === 8'hzz) || (d === 8'hFF)}, 8'h01);
        wr(8'hD6, 8'hFF);
        wr(8'hD7, 8'h55);
        rd(8'hD4, d);
        chk("ctrl_unchanged", d, 8'h00);
        rd(8'hD5, d);
        chk("blink_unchanged", d, 8'h02);
        wr(8'hD4, 8'hF1);
        repeat (5) tick();
        rd(8'hD6, d);
        chk("status_index", d, m_rd);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            d  = 8'($urandom);
            if (op <= 3) begin
                wr(8'hD0 + 8'($urandom_range(0, 3)), d);
            end else if (op == 4) begin
                wr(8'hD5, d);
            end else if (op == 5) begin
                if ($urandom_range(0, 7) != 0) d[0] = 1'b1;
                wr(8'hD4, d);
            end else if (op <= 7) begin
                rd(8'hD0 + 8'($urandom_range(0, 8)), s1);
            end else if (op == 8) begin
                if ($urandom_range(0, 1) == 0) wr(8'($urandom_range(214, 255)), d);
                else wr(8'($urandom_range(0, 207)), d);
            end else begin
                repeat ($urandom_range(1, 20)) tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
